hazard_flush_unit: RTL
======================

HAZARD_FLUSH_UNIT -- requirements
Module: hazard_flush_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a taken branch (legal range 1..7).
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 Parameter REG_W, default 5, register-index width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 branch_taken  in  1  EX stage resolved a taken branch/jump this cycle.
REQ-007 branch_target  in  ADDR_W  redirect address, valid with branch_taken.
REQ-008 ex_readdmem  in  1  instruction in EX is a load.
REQ-009 ex_rd  in  REG_W  destination register of the EX instruction.
REQ-010 id_rs, id_rt  in  REG_W each  source registers of the ID instruction.
REQ-011 flush  out  1  zero ID-stage control signals this cycle.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 ifid_write  out  1  IF/ID register update enable.
REQ-014 redirect_valid  out  1  one-cycle pulse, load redirect_pc into PC.
REQ-015 redirect_pc  out  ADDR_W  registered branch target.

Function
REQ-016 FSM states IDLE, FLUSH, STALL; a FLUSH_CYCLES-wide down-counter cnt (3 bits) is used in FLUSH.
REQ-017 load_use = ex_readdmem & (ex_rd != 0) & ((ex_rd == id_rs) | (ex_rd == id_rt)), combinational.
REQ-018 Taken branch sampled at edge N (any state): next state FLUSH, cnt <= FLUSH_CYCLES-1, redirect_pc <= branch_target, redirect_valid = 1 in cycle N+1 only.
REQ-019 In FLUSH: flush = 1, pc_write = 1, ifid_write = 1; cnt decrements each cycle; at cnt == 0 with no new branch -> IDLE; flush therefore high exactly cycles N+1..N+FLUSH_CYCLES.
REQ-020 A branch_taken during FLUSH restarts the sequence (new target, cnt reloaded, new redirect_valid pulse); flush stays high continuously.
REQ-021 In IDLE with load_use and no branch_taken: same-cycle combinational flush = 1, pc_write = 0, ifid_write = 0; next state STALL.
REQ-022 In STALL: load_use is masked, flush = 0, pc_write = ifid_write = 1; next state IDLE unless branch_taken (-> FLUSH).
REQ-023 branch_taken has priority over load_use in the same cycle; load_use in FLUSH is ignored.
REQ-024 IDLE with no events: flush = 0, pc_write = 1, ifid_write = 1, redirect_valid = 0.

Reset
REQ-025 While rst_n = 0: state IDLE, cnt = 0, redirect_pc = 0, redirect_valid = 0, flush = 0, pc_write = 1, ifid_write = 1.
REQ-026 Reset asserted mid-FLUSH or mid-STALL aborts immediately; no redirect_valid pulse after release until a new branch_taken.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN: when defined, adds outputs flush_count and stall_count (16 bits each, saturating at 0xFFFF, cleared by reset), incremented once per branch redirect and once per load-use bubble respectively.
REQ-028 Without HAZARD_PERF_CNT_EN the counter ports and logic do not exist; all other behaviour is identical.

Structure
REQ-029 Shared package hazard_pkg holds the state enumeration, the default FLUSH_CYCLES constant and the counter width constant.
REQ-030 The load_use comparator is a sub-module load_use_detect (pure combinational); the FSM and counter stay in the top module.

Verification
REQ-031 Reset release, no events for 10 cycles -> flush = 0, pc_write = ifid_write = 1, redirect_valid never high.
REQ-032 branch_taken = 1 with target 0x0000_0040 in cycle 5 -> redirect_valid = 1 and redirect_pc = 0x40 in cycle 6 only; flush high in cycles 6-7; IDLE at cycle 8.
REQ-033 ex_readdmem = 1, ex_rd = 3, id_rs = 3 -> same cycle flush = 1, pc_write = 0, ifid_write = 0; next cycle all released despite inputs held.
REQ-034 ex_rd = 0 with id_rs = 0 and ex_readdmem = 1 -> no stall.
REQ-035 branch_taken (target 0x80) and load_use in same cycle, then second branch (target 0xC0) during FLUSH -> no stall, two redirect pulses carrying 0x80 then 0xC0, flush continuous until FLUSH_CYCLES after the second branch.
REQ-036 rst_n pulled low mid-FLUSH -> outputs at reset values immediately; with HAZARD_PERF_CNT_EN, counters read 0 afterwards.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int FLUSH_CYCLES_DEFAULT = 2;
    localparam int CNT_W                = 3;
    localparam int PERF_W               = 16;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_flush_unit_load_use.sv
// Load-use hazard comparator: EX load writing a register the ID instruction reads.
// Latency: purely combinational.
// Backpressure: none; result feeds the stall decision in the same cycle.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_readdmem,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_readdmem && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/hazard_flush_unit.sv
// Branch flush / load-use stall controller; HAZARD_PERF_CNT_EN adds event counters.
// Latency: redirect one cycle after branch_taken; load-use stall asserted in the same cycle.
// Backpressure: stalls PC and IF/ID for exactly one bubble per load-use hazard.
module hazard_flush_unit
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
    parameter int ADDR_W       = 32,
    parameter int REG_W        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              ex_readdmem,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    output logic              flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] flush_count,
    output logic [PERF_W-1:0] stall_count
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             bubble;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .ex_readdmem (ex_readdmem),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    // Bubble only from IDLE: STALL masks the held hazard, FLUSH discards it,
    // and a same-cycle branch wins. Gated by rst_n so reset outputs are clean.
    assign bubble     = rst_n && (state == ST_IDLE) && load_use && !branch_taken;
    assign flush      = (state == ST_FLUSH) || bubble;
    assign pc_write   = !bubble;
    assign ifid_write = !bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            redirect_pc    <= '0;
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= branch_taken;
            if (branch_taken) begin
                state       <= ST_FLUSH;
                cnt         <= CNT_W'(FLUSH_CYCLES - 1);
                redirect_pc <= branch_target;
            end else begin
                case (state)
                    ST_IDLE:  if (load_use) state <= ST_STALL;
                    ST_FLUSH: begin
                        if (cnt == '0) state <= ST_IDLE;
                        else           cnt   <= cnt - 1'b1;
                    end
                    ST_STALL: state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (branch_taken) flush_count <= sat_inc(flush_count);
            if (bubble)       stall_count <= sat_inc(stall_count);
        end
    end
`endif

endmodule
